// File: rtl/input_conditioner.sv
// Synchronizes, prescale-samples and debounces a raw key/switch level.
// Define INPUT_CONDITIONER_INVERT_EN to invert key_raw ahead of the synchronizer (active-low keys).
module input_conditioner #(
  parameter int DIV_WIDTH      = 20,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic en,
  output logic a,
  output logic changed
);

  localparam int STAB_W = $clog2(STABLE_SAMPLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);

  logic key_in;
`ifdef INPUT_CONDITIONER_INVERT_EN
  assign key_in = ~key_raw;
`else
  assign key_in = key_raw;
`endif

  logic                 sync1_q, sync1_d;
  logic                 sync_q, sync_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 en_q, en_d;
  logic [STAB_W-1:0]    stab_q, stab_d;
  logic                 a_q, a_d;
  logic                 changed_q, changed_d;

  always_comb begin
    sync1_d   = key_in;
    sync_d    = sync1_q;
    presc_d   = presc_q + 1'b1;
    // en_q is high during the cycle in which presc_q holds all-ones
    en_d      = (presc_d == '1);
    stab_d    = stab_q;
    a_d       = a_q;
    changed_d = 1'b0;
    if (en_q) begin
      if (sync_q == a_q) begin
        stab_d = '0;
      end else if (stab_q == STAB_LAST) begin
        a_d       = sync_q;
        stab_d    = '0;
        changed_d = 1'b1;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      presc_q   <= '0;
      en_q      <= 1'b0;
      stab_q    <= '0;
      a_q       <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync_q    <= sync_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      stab_q    <= stab_d;
      a_q       <= a_d;
      changed_q <= changed_d;
    end
  end

  assign en      = en_q;
  assign a       = a_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (DIV_WIDTH=4, STABLE_SAMPLES=3): directed and random key
// waveforms checked cycle by cycle against a strobe-sample reference model.
module tb_input_conditioner;

  localparam int DW  = 4;
  localparam int S   = 3;
  localparam int PER = 1 << DW;
`ifdef INPUT_CONDITIONER_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic key_raw;
  logic en, a, changed;

  input_conditioner #(.DIV_WIDTH(DW), .STABLE_SAMPLES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_raw (key_raw),
    .en      (en),
    .a       (a),
    .changed (changed)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int cyc;
  bit hist [0:8191];
  bit samp [$];
  bit exp_a, exp_en, exp_chg;

  task automatic chk(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_outputs();
    chk("en", en, exp_en);
    chk("a", a, exp_a);
    chk("changed", changed, exp_chg);
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
    hist[0] = key_raw ^ INV;
    samp.delete();
    exp_a   = 1'b0;
    exp_en  = 1'b0;
    exp_chg = 1'b0;
  endtask

  // asserted just after a check point, i.e. in the middle of a cycle
  task automatic pulse_rst();
    reset_n = 1'b0;
    #1;
    exp_a = 1'b0; exp_en = 1'b0; exp_chg = 1'b0;
    chk_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_outputs();
    release_rst();
  endtask

  // advance one clock; k is the key level applied for the new cycle
  task automatic step(input logic k);
    bit s;
    int n;
    s = (cyc >= 2) ? hist[cyc-2] : 1'b0;
    exp_chg = 1'b0;
    if ((cyc % PER) == PER - 1) begin
      samp.push_back(s);
      n = 0;
      if (samp.size() >= S)
        for (int i = 0; i < S; i++)
          if (samp[samp.size()-1-i] != exp_a) n++;
      if (n == S) begin
        exp_a   = s;
        exp_chg = 1'b1;
        samp.delete();
      end
    end
    exp_en = (((cyc + 1) % PER) == PER - 1);
    @(posedge clk);
    cyc++;
    #1;
    chk_outputs();
    key_raw   = k;
    hist[cyc] = k ^ INV;
  endtask

  initial begin
    reset_n = 1'b0;
    key_raw = 1'b0;
    #2;
    exp_a = 1'b0; exp_en = 1'b0; exp_chg = 1'b0; cyc = 0;
    chk_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_outputs();

    // idle key: strobes only
    release_rst();
    repeat (70) step(1'b0);

    // clean 0 -> 1 step at cycle 20
    key_raw = 1'b0;
    pulse_rst();
    repeat (100) begin
      step((cyc + 1) >= 20);
`ifndef INPUT_CONDITIONER_INVERT_EN
      if (cyc == 64) begin
        chk("a_at_64", a, 1'b1);
        chk("changed_at_64", changed, 1'b1);
      end
      if (cyc == 63) chk("a_at_63", a, 1'b0);
`endif
    end

    // periodic bounce 20 high / 10 low
    key_raw = 1'b0;
    pulse_rst();
    repeat (200) step(((cyc + 1) % 30) < 20);

    // reset in the middle of stability counting
    key_raw = 1'b0;
    pulse_rst();
    repeat (50) step((cyc + 1) >= 20);
    pulse_rst();
    repeat (100) step(1'b1);

    // random holds and bounce bursts
    key_raw = 1'b0;
    pulse_rst();
    for (int seg = 0; seg < 60; seg++) begin
      logic lvl;
      int   hold, burst;
      lvl   = 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 80);
      burst = $urandom_range(0, 10);
      repeat (burst) step(1'($urandom_range(0, 1)));
      repeat (hold) step(lvl);
      if (seg == 30) pulse_rst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
